// File: rtl/lamp_sequencer.sv
// One-hot lamp sequencer with dwell timing and forward/reverse/ping-pong/hold modes.
// Optional blank phase between lamps is built when LAMP_BLANK_EN is defined.
module lamp_sequencer #(
    parameter  int NUM_LAMPS = 4,
    parameter  int DWELL_W   = 8,
    localparam int IDX_W     = (NUM_LAMPS > 1) ? $clog2(NUM_LAMPS) : 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [0:NUM_LAMPS-1] light,
    output logic [IDX_W-1:0]   state_idx,
    output logic               step
);

    localparam logic [1:0] MODE_FWD  = 2'b00;
    localparam logic [1:0] MODE_REV  = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;

`ifdef LAMP_BLANK_EN
    typedef enum logic {PH_LIT = 1'b0, PH_BLANK = 1'b1} phase_t;
    phase_t phase_r;
    phase_t phase_nxt_s;
`endif

    logic [IDX_W-1:0]   idx_r;
    logic [DWELL_W-1:0] cnt_r;
    logic               dir_up_r;
    logic               step_r;

    logic [IDX_W-1:0]   idx_adv_s;
    logic               dir_adv_s;
    logic [IDX_W-1:0]   idx_nxt_s;
    logic [DWELL_W-1:0] cnt_nxt_s;
    logic               dir_nxt_s;
    logic               step_nxt_s;
    logic               lit_s;

    // Index and direction the sequencer would move to on an advance.
    always_comb begin
        int cur_v;
        int nxt_v;
        cur_v     = int'(idx_r);
        nxt_v     = 0;
        dir_adv_s = dir_up_r;
        if (cur_v >= NUM_LAMPS) begin
            // Corrupted index recovers to lamp 0.
            nxt_v = 0;
        end else begin
            case (mode)
                MODE_FWD: begin
                    dir_adv_s = 1'b1;
                    nxt_v     = (cur_v == NUM_LAMPS - 1) ? 0 : cur_v + 1;
                end
                MODE_REV: begin
                    dir_adv_s = 1'b0;
                    nxt_v     = (cur_v == 0) ? NUM_LAMPS - 1 : cur_v - 1;
                end
                MODE_PING: begin
                    if (NUM_LAMPS == 1) begin
                        nxt_v = 0;
                    end else if (dir_up_r) begin
                        dir_adv_s = (cur_v != NUM_LAMPS - 1);
                        nxt_v     = (cur_v == NUM_LAMPS - 1) ? cur_v - 1 : cur_v + 1;
                    end else begin
                        dir_adv_s = (cur_v == 0);
                        nxt_v     = (cur_v == 0) ? 1 : cur_v - 1;
                    end
                end
                default: begin
                    nxt_v = cur_v;
                end
            endcase
        end
        idx_adv_s = IDX_W'(nxt_v);
    end

    // Dwell counter, advance decision and next register values.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        idx_nxt_s  = idx_r;
        dir_nxt_s  = dir_up_r;
        step_nxt_s = 1'b0;
`ifdef LAMP_BLANK_EN
        phase_nxt_s = phase_r;
`endif
        if (enable) begin
            if (mode == 2'b11) begin
                cnt_nxt_s = {DWELL_W{1'b0}};
`ifdef LAMP_BLANK_EN
                phase_nxt_s = PH_LIT;
`endif
            end else if (cnt_r >= dwell) begin
                cnt_nxt_s = {DWELL_W{1'b0}};
`ifdef LAMP_BLANK_EN
                if (phase_r == PH_LIT) begin
                    phase_nxt_s = PH_BLANK;
                end else begin
                    phase_nxt_s = PH_LIT;
                    idx_nxt_s   = idx_adv_s;
                    dir_nxt_s   = dir_adv_s;
                    step_nxt_s  = 1'b1;
                end
`else
                idx_nxt_s  = idx_adv_s;
                dir_nxt_s  = dir_adv_s;
                step_nxt_s = 1'b1;
`endif
            end else begin
                // Counter stays at or below dwell, so it cannot wrap.
                cnt_nxt_s = cnt_r + DWELL_W'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_r    <= {IDX_W{1'b0}};
            cnt_r    <= {DWELL_W{1'b0}};
            dir_up_r <= 1'b1;
            step_r   <= 1'b0;
`ifdef LAMP_BLANK_EN
            phase_r  <= PH_LIT;
`endif
        end else begin
            idx_r    <= idx_nxt_s;
            cnt_r    <= cnt_nxt_s;
            dir_up_r <= dir_nxt_s;
            step_r   <= step_nxt_s;
`ifdef LAMP_BLANK_EN
            phase_r  <= phase_nxt_s;
`endif
        end
    end

`ifdef LAMP_BLANK_EN
    assign lit_s = (phase_r == PH_LIT);
`else
    assign lit_s = 1'b1;
`endif

    // Lamp drive decoded from the state register only.
    always_comb begin
        light = {NUM_LAMPS{1'b0}};
        for (int i = 0; i < NUM_LAMPS; i++) begin
            light[i] = lit_s && (int'(idx_r) == i);
        end
    end

    assign state_idx = idx_r;
    assign step      = step_r;

endmodule
